// File: rtl/regfile_sum_ctrl.sv
// Register-file sum controller: reads a run of registers, accumulates them and writes the sum back.
// Define REGFILE_SUM_SAT_EN to make the accumulator saturate at all-ones instead of wrapping.
module regfile_sum_ctrl #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW:0]   count,
  input  logic [AW-1:0] dst_addr,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum_out,
  output logic          overflow,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] wData,
  output logic          we,
  output logic [AW-1:0] rAddr,
  input  logic [DW-1:0] rData
);

  localparam logic [AW:0] NREG = (AW+1)'(1 << AW);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [AW:0]   idx;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] acc;
  logic [DW-1:0] acc_next;
  logic [DW:0]   sum_ext;
  logic          carry;
  logic [AW:0]   count_clamped;

  assign count_clamped = (count > NREG) ? NREG : count;
  assign sum_ext       = {1'b0, acc} + {1'b0, rData};
  assign carry         = sum_ext[DW];

`ifdef REGFILE_SUM_SAT_EN
  // Once acc is all-ones any addend carries, so it sticks at all-ones.
  assign acc_next = carry ? {DW{1'b1}} : sum_ext[DW-1:0];
`else
  assign acc_next = sum_ext[DW-1:0];
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    we         = 1'b0;
    wAddr      = '0;
    wData      = '0;
    rAddr      = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = (count_clamped == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        rAddr = src_q + idx[AW-1:0];
        if (idx + ONE == cnt_q) state_next = S_WRITE;
      end
      S_WRITE: begin
        we         = 1'b1;
        wAddr      = dst_q;
        wData      = acc;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      acc      <= '0;
      sum_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q    <= src_base;
            dst_q    <= dst_addr;
            cnt_q    <= count_clamped;
            acc      <= '0;
            idx      <= '0;
            overflow <= 1'b0;
            sum_out  <= '0;
          end
        end
        S_READ: begin
          acc      <= acc_next;
          overflow <= overflow | carry;
          idx      <= idx + ONE;
        end
        S_WRITE: sum_out <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regfile_sum_ctrl.md
Name: regfile_sum_ctrl

Overview:
- Initiator-side controller that drives the 8x32 register file's write and read ports (wAddr/wData/we, rAddr/rData).
- On a start command it reads a run of consecutive registers and accumulates them into a 32-bit sum.
- It then writes the sum back to a destination register and pulses done.
- Sits between a host/test sequencer and the register file. It is the master; the register file is the responder.

Parameters:
- DW, 32, data width; must match register file data width.
- AW, 3, register address width (8 registers).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle command strobe; sampled only in IDLE
- src_base  input  AW  first register to read
- count  input  AW+1  registers to sum, 0..8; values >8 clamp to 8
- dst_addr  input  AW  register receiving the sum
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at end of operation
- sum_out  output  DW  final sum, held until next start
- overflow  output  1  carry-out occurred during last operation, held until next start
- wAddr  output  AW  register file write address
- wData  output  DW  register file write data
- we  output  1  register file write enable
- rAddr  output  AW  register file read address
- rData  input  DW  register file read data (combinational w.r.t. rAddr)

Behaviour:
- States: IDLE, READ, WRITE, DONE. All state, counter and accumulator registers update on rising clk only.
- Reset (synchronous, reset=1 at an edge): state=IDLE, idx=0, acc=0, sum_out=0, overflow=0, done=0. Applies mid-operation too: any pending write is abandoned and we=0 from that edge.
- IDLE:
  - busy=0, we=0, rAddr=0, wAddr=0, wData=0.
  - On start=1, latch src_base, dst_addr and clamped count into internal registers; clear acc, idx and overflow.
  - If clamped count=0, go to DONE (no write). Otherwise go to READ.
- READ:
  - rAddr = (src_base_q + idx) mod 8; address wraps 7 -> 0.
  - Each cycle: acc <= acc + rData, truncated to DW. overflow <= overflow | carry-out.
  - idx increments each cycle. After count_q cycles, go to WRITE.
- WRITE (exactly 1 cycle):
  - we=1, wAddr=dst_addr_q, wData=acc.
  - sum_out <= acc. Next state is DONE.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- Latency: with start sampled at edge E0, READ occupies cycles E0+1..E0+N, WRITE is cycle E0+N+1, done is high in cycle E0+N+2. For count=0, done is high in cycle E0+1.
- start while busy=1 is ignored; no queuing.
- dst_addr inside the source range is legal: the write occurs after all reads, so reads see pre-operation values.
- Inputs src_base, dst_addr and count are don't-care except in the cycle start is sampled.
- we is never asserted outside WRITE.

Optional Feature:
- Macro: REGFILE_SUM_SAT_EN
- Defined: accumulation saturates at all-ones (0xFFFFFFFF). Once saturated, acc stays there. overflow is still set on the first carry.
- Undefined: accumulation wraps modulo 2^DW, as described in Behaviour.

Test Plan:
- Preload regs r[i]=i+1. start, src_base=2, count=3, dst_addr=7 -> rAddr sequence 2,3,4; we=1 with wAddr=7, wData=12 (0xC); done in cycle E0+5; sum_out=12; overflow=0; r7 reads back 12.
- Same preload. src_base=6, count=4, dst=0 -> rAddr sequence 6,7,0,1; sum = 7+8+1+2 = 18 written to r0; overflow=0.
- r0=0xFFFFFFFF, r1=0x2. src_base=0, count=2, dst=3:
  - Without SAT_EN: wData=0x00000001, overflow=1.
  - With REGFILE_SUM_SAT_EN: wData=0xFFFFFFFF, overflow=1.
- count=0 -> done high in cycle E0+1; we never asserted; sum_out=0. A separate case with count=12 behaves exactly as count=8 (8 READ cycles).
- Assert reset during the 2nd READ cycle of a count=5 op -> next cycle busy=0, we=0, sum_out=0, overflow=0; destination register unchanged.
- Pulse start again during READ with different src_base -> ignored; the original operation completes with the original result.
